fetch_align_unit: RTL and testbench

- Front-end fetch stage directly upstream of the instruction queue.
- Requests aligned 8-word lines from the I-cache and splits each line into a table of {PC, instruction} entries.
- Statically predicts JAL and backward branches, cuts the packet at the first stop point or at queue room, and hands one packet per handshake to the queue.
- Owns the fetch PC, redirect handling and queue-flush packets.

---
 rtl/fetch_align_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_align_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_unit.sv
// Fetch stage: owns the fetch PC, fetches aligned I-cache lines and slices them into
// {PC, instr} packets with static jump prediction. Optional: BACKWARD_BRANCH_PRED_EN.

module fetch_align_lane (
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        stop_o,
    output logic        taken_o,
    output logic        jalr_o,
    output logic [31:0] target_o
);
    logic [6:0]  opc;
    logic        is_jal, is_br, br_taken;
    logic [31:0] j_imm, b_imm;

    assign opc    = instr_i[6:0];
    assign is_jal = (opc == 7'b1101111);
    assign is_br  = (opc == 7'b1100011);
    assign jalr_o = (opc == 7'b1100111);
    assign j_imm  = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign b_imm  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

`ifdef BACKWARD_BRANCH_PRED_EN
    assign br_taken = is_br & instr_i[31];
`else
    assign br_taken = 1'b0;
`endif

    assign taken_o  = is_jal | br_taken;
    assign stop_o   = taken_o | jalr_o;
    assign target_o = pc_i + (is_br ? b_imm : j_imm);
endmodule

module fetch_align_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_WORDS   = 8,
    parameter int          TABLE_ENTRIES = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         ic_req_valid,
    input  logic                         ic_req_ready,
    output logic [31:0]                  ic_req_addr,
    input  logic                         ic_resp_valid,
    input  logic [32*FETCH_WORDS-1:0]    ic_resp_data,
    input  logic [7:0]                   q_room,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [64*TABLE_ENTRIES-1:0]  out_table,
    output logic [7:0]                   out_cut,
    output logic                         out_got_jump,
    output logic [31:0]                  out_jump_addr
);
    localparam int OFFW = $clog2(FETCH_WORDS);
    localparam int LB   = OFFW + 2;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, LINE, HOLD, STALL, DROP, FLUSH} state_e;

    state_e                                state_q;
    logic [31:0]                           fetch_pc_q;
    logic [FETCH_WORDS-1:0][31:0]          line_q;
    logic                                  out_valid_q, got_jump_q, end_jalr_q;
    logic [TABLE_ENTRIES-1:0][63:0]        table_q;
    logic [7:0]                            cut_q;
    logic [31:0]                           jump_addr_q;

    logic [FETCH_WORDS-1:0][31:0]          lane_instr, lane_pc, lane_tgt;
    logic [FETCH_WORDS-1:0]                lane_stop, lane_taken, lane_jalr;
    logic [OFFW-1:0]                       start, last;
    logic [31:0]                           line_base;

    assign start     = fetch_pc_q[LB-1:2];
    assign line_base = {fetch_pc_q[31:LB], {LB{1'b0}}};

    // Lane g carries word start+g; lanes past the end of the line see a zero word.
    for (genvar g = 0; g < FETCH_WORDS; g++) begin : g_lane
        logic [OFFW:0] idx;
        assign idx           = {1'b0, start} + (OFFW+1)'(g);
        assign lane_instr[g] = (idx < (OFFW+1)'(FETCH_WORDS)) ? line_q[idx[OFFW-1:0]] : '0;
        assign lane_pc[g]    = line_base + {{(30-OFFW-1){1'b0}}, idx, 2'b00};

        fetch_align_lane u_lane (
            .instr_i  (lane_instr[g]),
            .pc_i     (lane_pc[g]),
            .stop_o   (lane_stop[g]),
            .taken_o  (lane_taken[g]),
            .jalr_o   (lane_jalr[g]),
            .target_o (lane_tgt[g])
        );
    end

    logic [7:0]                     stop_lim, avail, cnt, pkt_cut;
    logic [TABLE_ENTRIES-1:0][63:0] pkt_table;
    logic                           pkt_jump;
    logic [31:0]                    pkt_jump_addr, pkt_next_pc;

    always_comb begin
        stop_lim = 8'(FETCH_WORDS);
        for (int i = FETCH_WORDS - 1; i >= 0; i--)
            if (lane_stop[i]) stop_lim = 8'(i + 1);
        avail = 8'(FETCH_WORDS) - 8'(start);
        cnt   = avail;
        if (q_room < cnt)   cnt = q_room;
        if (stop_lim < cnt) cnt = stop_lim;
        pkt_cut   = cnt - 8'd1;
        last      = pkt_cut[OFFW-1:0];
        pkt_table = '0;
        for (int i = 0; i < FETCH_WORDS; i++)
            if (8'(i) <= pkt_cut) pkt_table[i] = {lane_pc[i], lane_instr[i]};
        pkt_jump      = lane_taken[last];
        pkt_jump_addr = pkt_jump ? lane_tgt[last] : 32'd0;
        pkt_next_pc   = pkt_jump ? lane_tgt[last] : lane_pc[last] + 32'd4;
    end

    // A redirect abandons in-flight work; an accepted request still owes a response.
    logic enter_flush, to_drop;
    assign to_drop     = redirect_valid && (state_q == WAIT || (state_q == REQ && ic_req_ready));
    assign enter_flush = (state_q == DROP && ic_resp_valid) ||
                         (redirect_valid && !(state_q inside {FLUSH, DROP, WAIT}) && !to_drop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            line_q      <= '0;
            out_valid_q <= 1'b0;
            table_q     <= '0;
            cut_q       <= '0;
            got_jump_q  <= 1'b0;
            jump_addr_q <= '0;
            end_jalr_q  <= 1'b0;
        end else begin
            if (enter_flush) begin
                state_q     <= FLUSH;
                out_valid_q <= 1'b1;
                table_q     <= '0;
                cut_q       <= 8'hFF;
                got_jump_q  <= 1'b0;
                jump_addr_q <= '0;
            end else if (to_drop) begin
                state_q <= DROP;
            end else if (!redirect_valid || state_q == FLUSH) begin
                case (state_q)
                    IDLE: state_q <= REQ;
                    REQ:  if (ic_req_ready) state_q <= WAIT;
                    WAIT: if (ic_resp_valid) begin
                        line_q  <= ic_resp_data;
                        state_q <= LINE;
                    end
                    LINE: if (q_room != 8'd0) begin
                        table_q     <= pkt_table;
                        cut_q       <= pkt_cut;
                        got_jump_q  <= pkt_jump;
                        jump_addr_q <= pkt_jump_addr;
                        end_jalr_q  <= lane_jalr[last];
                        fetch_pc_q  <= pkt_next_pc;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                    HOLD: if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= end_jalr_q ? STALL : REQ;
                    end
                    FLUSH: if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= REQ;
                    end
                    default: ;
                endcase
            end
            if (redirect_valid) fetch_pc_q <= redirect_pc;
        end
    end

    assign ic_req_valid  = (state_q == REQ);
    assign ic_req_addr   = (state_q == REQ) ? line_base : 32'd0;
    assign out_valid     = out_valid_q;
    assign out_table     = table_q;
    assign out_cut       = cut_q;
    assign out_got_jump  = got_jump_q;
    assign out_jump_addr = jump_addr_q;
endmodule

// File: tb/tb_fetch_align_unit.sv
// Directed bench for fetch_align_unit: hand-computed packets, redirects, stalls, wrap.
`timescale 1ns/1ps
module tb_fetch_align_unit;
    logic         clk = 1'b0;
    logic         rst;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         ic_req_valid, ic_req_ready;
    logic [31:0]  ic_req_addr;
    logic         ic_resp_valid;
    logic [255:0] ic_resp_data;
    logic [7:0]   q_room;
    logic         out_valid, out_ready;
    logic [639:0] out_table;
    logic [7:0]   out_cut;
    logic         out_got_jump;
    logic [31:0]  out_jump_addr;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_align_unit dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .q_room(q_room),
        .out_valid(out_valid), .out_ready(out_ready), .out_table(out_table), .out_cut(out_cut),
        .out_got_jump(out_got_jump), .out_jump_addr(out_jump_addr)
    );

    always #5 clk = ~clk;

`ifdef BACKWARD_BRANCH_PRED_EN
    localparam logic        BB_JUMP = 1'b1;
    localparam logic [31:0] BB_NEXT = 32'h0;
`else
    localparam logic        BB_JUMP = 1'b0;
    localparam logic [31:0] BB_NEXT = 32'h20;
`endif
    localparam logic [31:0] JAL_P40  = 32'h0400_006F;  // jal x0, +0x40
    localparam logic [31:0] BEQ_M28  = 32'hFE00_02E3;  // beq x0,x0,-28
    localparam logic [31:0] BEQ_P8   = 32'h0000_0463;  // beq x0,x0,+8
    localparam logic [31:0] JALR_X1  = 32'h0000_8067;  // jalr x0, 0(x1)

    function automatic logic [31:0] addi(int k);
        return {12'(k), 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    function automatic logic [255:0] mk_line(int seed);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = addi(seed*8 + k);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ent(string tag, int i, logic [31:0] pc, logic [31:0] ins);
        chk({tag, "_pc"},    out_table[i*64+32 +: 32], pc);
        chk({tag, "_instr"}, out_table[i*64 +: 32],    ins);
    endtask

    task automatic wait_req(string tag, logic [31:0] addr);
        int n = 0;
        while (!ic_req_valid && n < 20) begin tick(); n++; end
        chk({tag, "_req_valid"}, ic_req_valid, 1'b1);
        chk({tag, "_req_addr"},  ic_req_addr,  addr);
        ic_req_ready = 1'b1; tick(); ic_req_ready = 1'b0;
    endtask

    task automatic do_resp(logic [255:0] data);
        ic_resp_data = data; ic_resp_valid = 1'b1; tick(); ic_resp_valid = 1'b0;
    endtask

    task automatic wait_out(string tag);
        int n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk({tag, "_out_valid"}, out_valid, 1'b1);
    endtask

    task automatic accept();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic redirect(logic [31:0] pc);
        redirect_valid = 1'b1; redirect_pc = pc; tick(); redirect_valid = 1'b0;
    endtask

    task automatic chk_flush(string tag);
        chk({tag, "_fl_valid"}, out_valid,    1'b1);
        chk({tag, "_fl_cut"},   out_cut,      8'hFF);
        chk({tag, "_fl_jump"},  out_got_jump, 1'b0);
        chk({tag, "_fl_table"}, 64'(out_table == '0), 64'd1);
    endtask

    logic [255:0] ln;

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ic_req_ready = 1'b0;
        ic_resp_valid = 1'b0; ic_resp_data = '0; q_room = 8'd10; out_ready = 1'b0;
        tick(); tick();
        chk("rst_req_valid", ic_req_valid, 1'b0);
        chk("rst_req_addr",  ic_req_addr,  32'h0);
        chk("rst_out_valid", out_valid,    1'b0);
        chk("rst_cut",       out_cut,      8'h0);
        chk("rst_jump_addr", out_jump_addr, 32'h0);
        rst = 1'b1;

        // Full line from reset PC, latency N+2
        wait_req("t1", 32'h0);
        do_resp(mk_line(0));
        chk("t1_lat_n1", out_valid, 1'b0);
        tick();
        chk("t1_lat_n2", out_valid, 1'b1);
        chk("t1_cut", out_cut, 8'd7);
        chk("t1_jump", out_got_jump, 1'b0);
        chk("t1_jaddr", out_jump_addr, 32'h0);
        for (int i = 0; i < 8; i++) chk_ent("t1_e", i, 32'(i*4), addi(i));
        chk_ent("t1_e8", 8, 32'h0, 32'h0);
        chk_ent("t1_e9", 9, 32'h0, 32'h0);
        accept();
        chk("t1_next_valid", ic_req_valid, 1'b1);
        chk("t1_next_addr",  ic_req_addr,  32'h20);

        // Redirect from REQ -> flush, then mid-line start with limited room
        redirect(32'h108);
        chk_flush("t2");
        accept();
        wait_req("t2", 32'h100);
        q_room = 8'd3;
        do_resp(mk_line(1));
        wait_out("t2");
        chk("t2_cut", out_cut, 8'd2);
        chk_ent("t2_e0", 0, 32'h108, addi(10));
        chk_ent("t2_e1", 1, 32'h10C, addi(11));
        chk_ent("t2_e2", 2, 32'h110, addi(12));
        chk_ent("t2_e3", 3, 32'h0, 32'h0);
        accept();
        q_room = 8'd10;
        wait_req("t2b", 32'h100);
        do_resp(mk_line(2));
        wait_out("t2b");
        chk("t2b_cut", out_cut, 8'd2);
        chk_ent("t2b_e0", 0, 32'h114, addi(21));
        chk_ent("t2b_e2", 2, 32'h11C, addi(23));
        accept();
        chk("t2b_next_addr", ic_req_addr, 32'h120);

        // JAL at word 2
        redirect(32'h0);
        chk_flush("t3");
        accept();
        wait_req("t3", 32'h0);
        ln = mk_line(3); ln[2*32 +: 32] = JAL_P40;
        do_resp(ln);
        wait_out("t3");
        chk("t3_cut", out_cut, 8'd2);
        chk("t3_jump", out_got_jump, 1'b1);
        chk("t3_jaddr", out_jump_addr, 32'h48);
        chk_ent("t3_e2", 2, 32'h8, JAL_P40);
        chk_ent("t3_e3", 3, 32'h0, 32'h0);
        accept();
        chk("t3_next_addr", ic_req_addr, 32'h40);

        // Forward branch (never stops) and backward branch at the last word
        redirect(32'h0);
        accept();
        wait_req("t4", 32'h0);
        ln = mk_line(4); ln[3*32 +: 32] = BEQ_P8; ln[7*32 +: 32] = BEQ_M28;
        do_resp(ln);
        wait_out("t4");
        chk("t4_cut", out_cut, 8'd7);
        chk("t4_jump", out_got_jump, BB_JUMP);
        chk("t4_jaddr", out_jump_addr, 32'h0);
        chk_ent("t4_e3", 3, 32'hC, BEQ_P8);
        chk_ent("t4_e7", 7, 32'h1C, BEQ_M28);
        accept();
        wait_req("t4_next", BB_NEXT);

        // Redirect while waiting on the cache: stale line dropped, then flush
        redirect(32'h200);
        chk("t5_drop_valid0", out_valid, 1'b0);
        tick();
        chk("t5_drop_valid1", out_valid, 1'b0);
        chk("t5_drop_noreq", ic_req_valid, 1'b0);
        do_resp(mk_line(9));
        chk_flush("t5");
        accept();
        wait_req("t5", 32'h200);

        // No queue room: hold in LINE, then packet stays stable under backpressure
        q_room = 8'd0;
        do_resp(mk_line(5));
        for (int k = 0; k < 5; k++) begin chk("t6_noroom", out_valid, 1'b0); tick(); end
        q_room = 8'd4;
        tick();
        chk("t6_valid", out_valid, 1'b1);
        chk("t6_cut", out_cut, 8'd3);
        q_room = 8'd1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_hold_cut", out_cut, 8'd3);
            chk_ent("t6_hold_e0", 0, 32'h200, addi(40));
        end
        accept();
        q_room = 8'd10;
        wait_req("t6_next", 32'h200);

        // Redirect beats out_ready in HOLD
        do_resp(mk_line(6));
        wait_out("t7");
        chk("t7_cut", out_cut, 8'd3);
        chk_ent("t7_e0", 0, 32'h210, addi(52));
        out_ready = 1'b1;
        redirect(32'h300);
        out_ready = 1'b0;
        chk_flush("t7");
        accept();
        wait_req("t7", 32'h300);

        // JALR stalls fetch until redirect
        ln = mk_line(8); ln[31:0] = JALR_X1;
        do_resp(ln);
        wait_out("t8");
        chk("t8_cut", out_cut, 8'd0);
        chk("t8_jump", out_got_jump, 1'b0);
        chk_ent("t8_e1", 1, 32'h0, 32'h0);
        accept();
        for (int k = 0; k < 4; k++) begin chk("t8_stall", ic_req_valid, 1'b0); tick(); end
        redirect(32'hFFFF_FFFC);
        chk_flush("t8");
        accept();

        // Top-of-memory fetch wraps to zero
        wait_req("t9", 32'hFFFF_FFE0);
        do_resp(mk_line(7));
        wait_out("t9");
        chk("t9_cut", out_cut, 8'd0);
        chk_ent("t9_e0", 0, 32'hFFFF_FFFC, addi(63));
        accept();
        wait_req("t9_wrap", 32'h0);

        // Reset while a request is outstanding
        rst = 1'b0;
        tick();
        chk("t10_req_valid", ic_req_valid, 1'b0);
        chk("t10_out_valid", out_valid, 1'b0);
        rst = 1'b1;
        wait_req("t10", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
